beep_seq: RTL and testbench

BEEP_SEQ -- requirements
Module: beep_seq

---
 rtl/beep_seq.sv | 129 ++++++++++++
 tb/tb_beep_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/beep_seq.sv
// Segmented two-tone buzzer sequencer: plays SEG_NUM segments of SEG_LEN cycles,
// with the tone of each segment chosen by the mode latched when go is accepted.
//
// state | meaning
// IDLE  | waiting for go; outputs and counters cleared
// PLAY  | sequence running, busy=1
// DONE  | sequence finished, over=1 until go or abort
module beep_seq #(
    parameter int SEG_LEN = 500,
    parameter int SEG_NUM = 10,
    parameter int HALF_A  = 1,
    parameter int HALF_B  = 2,
    localparam int SEG_W  = (SEG_NUM > 1) ? $clog2(SEG_NUM) : 1,
    localparam int LEN_W  = $clog2(SEG_LEN),
    localparam int HMAX   = (HALF_A > HALF_B) ? HALF_A : HALF_B,
    localparam int TW     = (HMAX > 1) ? $clog2(HMAX) : 1
) (
    input  logic             clk,
    input  logic             st,
    input  logic             go,
    input  logic             abort,
    input  logic [1:0]       mode,
    output logic             beep,
    output logic             busy,
    output logic             over,
    output logic [SEG_W-1:0] seg_idx
);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(SEG_LEN - 1);
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEG_NUM - 1);
    localparam logic [TW-1:0]    A_TOP    = TW'(HALF_A - 1);
    localparam logic [TW-1:0]    B_TOP    = TW'(HALF_B - 1);

    state_t           state, state_d;
    logic [LEN_W-1:0] seg_cnt, seg_cnt_d;
    logic [SEG_W-1:0] seg_idx_d;
    logic [TW-1:0]    tone_cnt, tone_d, tone_top;
    logic [1:0]       mode_q, mode_d;
    logic             beep_d, over_d, use_b, tone_on, seg_end;

    // Tone choice for the current segment from the latched mode
    assign use_b    = (mode_q == 2'd2) || ((mode_q == 2'd0) && seg_idx[0]);
    assign tone_on  = !((mode_q == 2'd3) && seg_idx[0]);
    assign tone_top = use_b ? B_TOP : A_TOP;
    assign seg_end  = (seg_cnt == LEN_LAST);
    assign busy     = (state == PLAY);

    always_ff @(posedge clk or negedge st) begin
        if (!st) begin
            state    <= IDLE;
            seg_cnt  <= '0;
            seg_idx  <= '0;
            tone_cnt <= '0;
            beep     <= 1'b0;
            over     <= 1'b0;
            mode_q   <= 2'd0;
        end else begin
            state    <= state_d;
            seg_cnt  <= seg_cnt_d;
            seg_idx  <= seg_idx_d;
            tone_cnt <= tone_d;
            beep     <= beep_d;
            over     <= over_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d   = state;
        seg_cnt_d = seg_cnt;
        seg_idx_d = seg_idx;
        tone_d    = tone_cnt;
        beep_d    = beep;
        over_d    = over;
        mode_d    = mode_q;
        case (state)
            IDLE, DONE: begin
                if (abort) begin
                    state_d = IDLE;
                    over_d  = 1'b0;
                end else if (go) begin
                    state_d   = PLAY;
                    seg_cnt_d = '0;
                    seg_idx_d = '0;
                    tone_d    = '0;
                    beep_d    = 1'b0;
                    over_d    = 1'b0;
                    mode_d    = mode;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_d   = IDLE;
                    seg_cnt_d = '0;
                    seg_idx_d = '0;
                    tone_d    = '0;
                    beep_d    = 1'b0;
                    over_d    = 1'b0;
                end else if (seg_end) begin
                    seg_cnt_d = '0;
                    tone_d    = '0;
                    beep_d    = 1'b0;
                    if (seg_idx == SEG_LAST) begin
                        state_d   = DONE;
                        over_d    = 1'b1;
                        seg_idx_d = '0;
                    end else begin
                        seg_idx_d = seg_idx + SEG_W'(1);
                    end
                end else begin
                    seg_cnt_d = seg_cnt + LEN_W'(1);
                    if (!tone_on) begin
                        tone_d = '0;
                        beep_d = 1'b0;
                    end else if (tone_cnt == tone_top) begin
                        tone_d = '0;
                        beep_d = ~beep;
                    end else begin
                        tone_d = tone_cnt + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_beep_seq.sv
// Bench for beep_seq: fixed vector table, hand-written corner sequences and
// randomized traffic against a closed-form model of the beep pattern.
module tb_beep_seq;

    localparam int SEG_LEN = 4;
    localparam int SEG_NUM = 3;
    localparam int HALF_A  = 1;
    localparam int HALF_B  = 2;

    logic       clk, st, go, abort;
    logic [1:0] mode;
    logic       beep, busy, over;
    logic [1:0] seg_idx;

    beep_seq #(.SEG_LEN(SEG_LEN), .SEG_NUM(SEG_NUM), .HALF_A(HALF_A), .HALF_B(HALF_B)) dut (
        .clk(clk), .st(st), .go(go), .abort(abort), .mode(mode),
        .beep(beep), .busy(busy), .over(over), .seg_idx(seg_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       go, abort;
        logic [1:0] mode;
        logic       beep, busy, over;
        logic [1:0] seg;
    } vec_t;

    vec_t tbl[$];
    int errors = 0;
    int checks = 0;

    // Reference model: position in the sequence, not counters
    bit m_play, m_over;
    int m_t, m_mode;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic addv(input logic g, a, input logic [1:0] m, input logic b, bs, o, input logic [1:0] s);
        vec_t v;
        v.go = g; v.abort = a; v.mode = m; v.beep = b; v.busy = bs; v.over = o; v.seg = s;
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        m_play = 0; m_over = 0; m_t = 0; m_mode = 0;
    endtask

    task automatic model_edge(input logic g, a, input logic [1:0] m);
        if (a) begin
            m_play = 0; m_over = 0;
        end else if (m_play) begin
            m_t++;
            if (m_t == SEG_LEN * SEG_NUM) begin
                m_play = 0; m_over = 1;
            end
        end else if (g) begin
            m_play = 1; m_t = 0; m_mode = int'(m); m_over = 0;
        end
    endtask

    task automatic chk_model(input string tag);
        int seg, pos, h, eb;
        seg = m_t / SEG_LEN;
        pos = m_t % SEG_LEN;
        if (m_mode == 1) h = HALF_A;
        else if (m_mode == 2) h = HALF_B;
        else h = (seg % 2 == 0) ? HALF_A : HALF_B;
        if (!m_play || (m_mode == 3 && seg % 2 == 1)) eb = 0;
        else eb = (pos / h) % 2;
        chk({tag, "_beep"}, int'(beep), eb);
        chk({tag, "_busy"}, int'(busy), int'(m_play));
        chk({tag, "_over"}, int'(over), int'(m_over));
        chk({tag, "_seg"},  int'(seg_idx), m_play ? seg : 0);
    endtask

    task automatic step(input logic g, a, input logic [1:0] m);
        @(negedge clk);
        go = g; abort = a; mode = m;
        @(posedge clk);
        model_edge(g, a, m);
        #1;
    endtask

    initial begin
        st = 1'b0; go = 1'b0; abort = 1'b0; mode = 2'd0;
        model_reset();
        #1;
        chk("rst_beep", int'(beep), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_over", int'(over), 0);
        chk("rst_seg",  int'(seg_idx), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        st = 1'b1;

        // mode 0 full sequence; go on the first edge after release
        addv(1,0,0, 0,1,0,0); addv(0,0,0, 1,1,0,0); addv(0,0,0, 0,1,0,0); addv(0,0,0, 1,1,0,0);
        addv(0,0,0, 0,1,0,1); addv(0,0,0, 0,1,0,1); addv(0,0,0, 1,1,0,1); addv(0,0,0, 1,1,0,1);
        addv(0,0,0, 0,1,0,2); addv(0,0,0, 1,1,0,2); addv(0,0,0, 0,1,0,2); addv(0,0,0, 1,1,0,2);
        addv(0,0,0, 0,0,1,0); addv(0,0,0, 0,0,1,0);
        // go+abort in DONE, then abort in IDLE
        addv(1,1,3, 0,0,0,0); addv(0,1,0, 0,0,0,0);
        // mode 3: silent odd segment
        addv(1,0,3, 0,1,0,0); addv(0,0,0, 1,1,0,0); addv(0,0,0, 0,1,0,0); addv(0,0,0, 1,1,0,0);
        addv(0,0,0, 0,1,0,1); addv(0,0,0, 0,1,0,1); addv(0,0,0, 0,1,0,1); addv(0,0,0, 0,1,0,1);
        addv(0,0,0, 0,1,0,2); addv(0,0,0, 1,1,0,2); addv(0,0,0, 0,1,0,2); addv(0,0,0, 1,1,0,2);
        addv(0,0,0, 0,0,1,0);
        // mode 1 with abort at E0+5, restart in mode 2
        addv(1,0,1, 0,1,0,0); addv(0,0,0, 1,1,0,0); addv(0,0,0, 0,1,0,0); addv(0,0,0, 1,1,0,0);
        addv(0,0,0, 0,1,0,1); addv(0,1,0, 0,0,0,0);
        addv(1,0,2, 0,1,0,0); addv(0,0,0, 0,1,0,0); addv(0,0,0, 1,1,0,0); addv(0,0,0, 1,1,0,0);
        addv(0,1,0, 0,0,0,0);

        foreach (tbl[i]) begin
            step(tbl[i].go, tbl[i].abort, tbl[i].mode);
            chk($sformatf("tbl%0d_beep", i), int'(beep),    int'(tbl[i].beep));
            chk($sformatf("tbl%0d_busy", i), int'(busy),    int'(tbl[i].busy));
            chk($sformatf("tbl%0d_over", i), int'(over),    int'(tbl[i].over));
            chk($sformatf("tbl%0d_seg",  i), int'(seg_idx), int'(tbl[i].seg));
        end

        // go held through PLAY while mode changes: latched mode 0 is kept
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, (k >= 2) ? 2'd2 : 2'd0);
            chk_model($sformatf("hold%0d", k));
        end
        step(1'b0, 1'b0, 2'd2);
        chk("hold_done_over", int'(over), 1);
        chk("hold_done_busy", int'(busy), 0);
        step(1'b1, 1'b0, 2'd2);
        chk("hold_restart_busy", int'(busy), 1);
        chk("hold_restart_over", int'(over), 0);
        chk_model("hold_restart");

        // async reset in segment 1
        step(1'b0, 1'b1, 2'd0);
        step(1'b1, 1'b0, 2'd0);
        repeat (5) step(1'b0, 1'b0, 2'd0);
        chk("pre_rst_seg", int'(seg_idx), 1);
        #2 st = 1'b0;
        #1;
        model_reset();
        chk("arst_beep", int'(beep), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_over", int'(over), 0);
        chk("arst_seg",  int'(seg_idx), 0);
        @(posedge clk);
        @(negedge clk);
        st = 1'b1;
        step(1'b1, 1'b0, 2'd1);
        chk("post_rst_busy", int'(busy), 1);
        chk_model("post_rst");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic g, a;
            logic [1:0] m;
            g = ($urandom_range(0, 7) == 0);
            a = ($urandom_range(0, 39) == 0);
            m = 2'($urandom_range(0, 3));
            step(g, a, m);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
